k_sort_ctrl: RTL

- Sequencing controller for the top-K sort/activation unit in PuDianNao's kNN/k-means path.
- Accepts one job (N candidate distances, direction, effective K) and clears the sorter.
- Streams candidates into the sorter with auto-generated indices, one insert per strobe, waits for the sorter to settle, then serialises the ranked results onto a valid/ready output.
- Sits between the distance-computation stream and the result writeback.

---
 rtl/k_sort_pkg.sv | 22 ++
 rtl/k_sort_ctrl_if.sv | 27 ++
 rtl/k_sort_res_serializer.sv | 54 +++++
 rtl/k_sort_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/k_sort_pkg.sv
// Shared types and helpers for the top-K sort sequencer.
package k_sort_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int K_DEF     = 20;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    DRAIN  = 3'd4,
    FINISH = 3'd5
  } state_t;

  // A requested K of zero, or one larger than the sorter, selects the full depth.
  function automatic int clamp_k(input int k_cfg, input int k_max);
    return (k_cfg == 0 || k_cfg > k_max) ? k_max : k_cfg;
  endfunction

endpackage

// File: rtl/k_sort_ctrl_if.sv
// Candidate input stream and ranked result stream of the top-K sequencer.
interface k_sort_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic [WIDTH-1:0] res_index;
  logic             res_last;

  // master: distance producer plus result consumer; slave: the sequencer
  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_index, res_last
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_index, res_last
  );

endinterface

// File: rtl/k_sort_res_serializer.sv
// Walks the sorter ranks 0..M-1 and presents them on a valid/ready stream.
module k_sort_res_serializer
  import k_sort_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int K     = K_DEF,
  localparam int KW    = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [KW-1:0]      m_cnt,
  input  logic [K*WIDTH-1:0] sort_value,
  input  logic [K*WIDTH-1:0] sort_vindex,
  input  logic               res_ready,
  output logic               res_valid,
  output logic [WIDTH-1:0]   res_data,
  output logic [WIDTH-1:0]   res_index,
  output logic               res_last,
  output logic               last_fire
);

  logic [KW-1:0] rank;
  logic          active;
  logic          fire;

  assign fire      = active && res_ready;
  assign res_valid = active;
  assign res_last  = active && (rank == m_cnt - KW'(1));
  assign last_fire = fire && res_last;

  // Rank is a flop and the sorter is frozen while draining, so the selected
  // beat cannot change until the consumer takes it.
  assign res_data  = active ? sort_value[int'(rank) * WIDTH +: WIDTH]  : '0;
  assign res_index = active ? sort_vindex[int'(rank) * WIDTH +: WIDTH] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      rank   <= '0;
    end else if (load) begin
      active <= 1'b1;
      rank   <= '0;
    end else if (fire) begin
      if (res_last) begin
        active <= 1'b0;
        rank   <= '0;
      end else begin
        rank <= rank + KW'(1);
      end
    end
  end

endmodule

// File: rtl/k_sort_ctrl.sv
// Top-K sort sequencer: clears the sorter, streams indexed candidates into it,
// waits for it to settle, then drains the ranked results.
module k_sort_ctrl
  import k_sort_pkg::*;
#(
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int K        = K_DEF,
  parameter  int CNT_W    = CNT_W_DEF,
  parameter  int SORT_LAT = 1,
  localparam int KW       = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic [CNT_W-1:0]   cfg_num,
  input  logic               cfg_asce,
  input  logic [KW-1:0]      cfg_k,
  output logic               busy,
  output logic               done,
  k_sort_ctrl_if.slave       io,
  output logic               sort_clear,
  output logic               sort_start,
  output logic               sort_strobe,
  output logic               sort_asce,
  output logic [WIDTH-1:0]   sort_in,
  output logic [WIDTH-1:0]   sort_index,
  input  logic [K*WIDTH-1:0] sort_value,
  input  logic [K*WIDTH-1:0] sort_vindex
);

  // state  | meaning
  // IDLE   | waiting for cfg_start
  // CLEAR  | one-cycle sorter clear
  // RUN    | accepting candidates until N taken
  // SETTLE | waiting SORT_LAT cycles after the last strobe
  // DRAIN  | serialising ranks 0..M-1
  // FINISH | one-cycle done pulse

  localparam int LAT_W = (SORT_LAT > 1) ? $clog2(SORT_LAT) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] num_q, cnt;
  logic [KW-1:0]    m_q, k_eff, m_next;
  logic [LAT_W-1:0] lat_cnt;
  logic             asce_q, strobe_q;
  logic [WIDTH-1:0] sort_in_q, sort_index_q;
  logic             accept, load_drain, last_fire;

  always_comb begin
    k_eff  = KW'(clamp_k(int'(cfg_k), K));
    m_next = (cfg_num < CNT_W'(k_eff)) ? KW'(cfg_num) : k_eff;
  end

  assign accept     = io.in_valid && io.in_ready;
  assign load_drain = (state != DRAIN) && (state_nx == DRAIN);

  always_comb begin
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    sort_clear  = 1'b0;
    sort_start  = 1'b0;
    io.in_ready = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) state_nx = CLEAR;
      end
      CLEAR: begin
        busy       = 1'b1;
        sort_clear = 1'b1;
        state_nx   = (num_q == '0) ? FINISH : RUN;
      end
      RUN: begin
        busy        = 1'b1;
        sort_start  = 1'b1;
        io.in_ready = (cnt < num_q);
        if (accept && (cnt == num_q - CNT_W'(1))) state_nx = SETTLE;
      end
      SETTLE: begin
        // the final strobe lands in the first SETTLE cycle, so keep the sorter enabled
        busy       = 1'b1;
        sort_start = 1'b1;
        if (lat_cnt == '0) state_nx = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_fire) state_nx = FINISH;
      end
      FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      num_q        <= '0;
      asce_q       <= 1'b0;
      m_q          <= '0;
      cnt          <= '0;
      strobe_q     <= 1'b0;
      sort_in_q    <= '0;
      sort_index_q <= '0;
      lat_cnt      <= '0;
    end else begin
      state    <= state_nx;
      strobe_q <= accept;
      if ((state == IDLE) && cfg_start) begin
        num_q  <= cfg_num;
        asce_q <= cfg_asce;
        m_q    <= m_next;
        cnt    <= '0;
      end
      if (accept) begin
        sort_in_q    <= io.in_data;
        sort_index_q <= WIDTH'(cnt);
        cnt          <= cnt + CNT_W'(1);
      end
      if ((state == RUN) && (state_nx == SETTLE)) begin
        lat_cnt <= LAT_W'(SORT_LAT - 1);
      end else if ((state == SETTLE) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

  assign sort_strobe = strobe_q;
  assign sort_in     = sort_in_q;
  assign sort_index  = sort_index_q;
  assign sort_asce   = asce_q;

  k_sort_res_serializer #(
    .WIDTH(WIDTH),
    .K    (K)
  ) u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_drain),
    .m_cnt      (m_q),
    .sort_value (sort_value),
    .sort_vindex(sort_vindex),
    .res_ready  (io.res_ready),
    .res_valid  (io.res_valid),
    .res_data   (io.res_data),
    .res_index  (io.res_index),
    .res_last   (io.res_last),
    .last_fire  (last_fire)
  );

endmodule
